// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle: level inputs captured once per frame, registered board outputs.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  // No handshake: value/dp_in/blank/lz_en are levels sampled on the frame_start
  // edge; an/seg/dp/frame_start/dbg_state are registered and valid every cycle.
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;
  state_e                  dbg_state;

  modport master (
    output value, dp_in, blank, lz_en,
    input  an, seg, dp, frame_start, dbg_state
  );

  modport slave (
    input  value, dp_in, blank, lz_en,
    output an, seg, dp, frame_start, dbg_state
  );

endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans NUM_DIGITS digits, one per rising edge of slowClk, with blanking between
// digits, a per-frame input snapshot and leading-zero suppression.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk100Mhz,
  input  logic            reset,
  input  logic            slowClk,
  seg7_scan_mux_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic                    s1_q, s2_q, s3_q;
  logic                    tick;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_in_q, blank_q;
  logic                    lz_q;
  logic                    snap_en;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;
  logic [3:0]              nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   dark;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    zero_above;
  logic [6:0]              font_seg;

  assign tick     = s2_q & ~s3_q;
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) nibs[i] = value_q[4*i +: 4];
  end

  // A digit is suppressed when it and every more significant nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    dark       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (nibs[i] == 4'd0);
      dark[i]    = blank_q[i] | (lz_q & zero_above & (i > 0));
    end
  end

  seg7_decode u_decode (
    .nibble_i (nibs[idx_q]),
    .seg_o    (font_seg)
  );

  always_ff @(posedge clk100Mhz) begin
    if (reset) state_q <= BLANK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      state_d = BLANK;
    end else begin
      case (state_q)
        BLANK:   if (cnt_q == CNT_LAST) state_d = DRIVE;
        DRIVE:   state_d = DRIVE;
        default: state_d = BLANK;
      endcase
    end
  end

  always_comb begin
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    snap_en = 1'b0;
    sel     = '0;
    sel[idx_q] = 1'b1;
    if (tick) begin
      idx_d = idx_next;
      cnt_d = '0;
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (idx_next == '0) begin
        snap_en = 1'b1;
        fs_d    = 1'b1;
      end
    end else if (state_q == BLANK) begin
      if (cnt_q == CNT_LAST) begin
        if (dark[idx_q]) begin
          an_d  = '1;
          seg_d = SEG_OFF;
          dp_d  = 1'b1;
        end else begin
          an_d  = ~sel;
          seg_d = font_seg;
          dp_d  = ~dp_in_q[idx_q];
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= LAST_IDX;
      value_q <= '0;
      dp_in_q <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      s1_q  <= slowClk;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
      if (snap_en) begin
        value_q <= bus.value;
        dp_in_q <= bus.dp_in;
        blank_q <= bus.blank;
        lz_q    <= bus.lz_en;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux against a cycle-level behavioural display model.
module tb_seg7_scan_mux;
  import seg7_pkg::*;

  localparam int N = 4;
  localparam int B = 16;
  localparam int W = 13;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic slowClk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_mux #(.NUM_DIGITS(N), .BLANK_CYCLES(B)) dut (
    .clk100Mhz (clk),
    .reset     (reset),
    .slowClk   (slowClk),
    .bus       (bus)
  );

  // 40-cycle-period scan square wave
  initial begin
    forever begin
      repeat (20) @(negedge clk);
      slowClk = ~slowClk;
    end
  end

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] font_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          m_digit = N - 1;
  int          m_since = 0;
  int          m_delay = 0;
  bit          m_prev  = 1'b0;
  bit          m_fs    = 1'b0;
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  m_blk   = '0;
  bit          m_lz    = 1'b0;

  function automatic logic [W-1:0] model_out();
    logic [15:0] upper;
    bit          lit;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    upper = m_val >> (4 * m_digit);
    lit   = (m_since >= B) && !m_blk[m_digit] && !(m_lz && m_digit > 0 && upper == 16'd0);
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (lit) begin
      an_e[m_digit] = 1'b0;
      seg_e = font_ref[upper[3:0]];
      dp_e  = ~m_dp[m_digit];
    end
    return {m_fs, dp_e, seg_e, an_e};
  endfunction

  // A rising slowClk seen at an edge becomes a digit step two edges later.
  always @(posedge clk) begin
    bit fire;
    fire = 1'b0;
    if (reset) begin
      m_digit = N - 1; m_since = 0; m_delay = 0; m_prev = 1'b0; m_fs = 1'b0;
      m_val = '0; m_dp = '0; m_blk = '0; m_lz = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (m_delay > 0) begin
        m_delay--;
        if (m_delay == 0) fire = 1'b1;
      end
      if (slowClk && !m_prev) m_delay = 2;
      m_prev = slowClk;
      if (fire) begin
        m_digit = (m_digit + 1) % N;
        m_since = 0;
        if (m_digit == 0) begin
          m_val = bus.value; m_dp = bus.dp_in; m_blk = bus.blank; m_lz = bus.lz_en;
          m_fs  = 1'b1;
        end
      end else if (m_since < B) begin
        m_since++;
      end
    end
    exp_q.push_back(model_out());
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("an",          32'(bus.an),          32'(e[3:0]));
      check_eq("seg",         32'(bus.seg),         32'(e[10:4]));
      check_eq("dp",          32'(bus.dp),          32'(e[11]));
      check_eq("frame_start", 32'(bus.frame_start), 32'(e[12]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] dpi,
                            input logic [3:0] blk, input logic lz);
    bus.value = v;
    bus.dp_in = dpi;
    bus.blank = blk;
    bus.lz_en = lz;
  endtask

  task automatic randomize_inputs();
    logic [15:0] mask;
    case ($urandom_range(0, 4))
      0:       mask = 16'hFFFF;
      1:       mask = 16'h0FFF;
      2:       mask = 16'h00FF;
      3:       mask = 16'h000F;
      default: mask = 16'h0000;
    endcase
    set_inputs(16'($urandom) & mask, 4'($urandom),
               ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
               1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    run_cycles(n);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0);
    run_cycles(3);
    check_eq("rst_an",    32'(bus.an),          32'h0000_000F);
    check_eq("rst_seg",   32'(bus.seg),         32'h0000_007F);
    check_eq("rst_dp",    32'(bus.dp),          32'h0000_0001);
    check_eq("rst_fs",    32'(bus.frame_start), 32'h0000_0000);
    check_eq("rst_state", 32'(bus.dbg_state),   32'(BLANK));
    reset = 1'b0;

    set_inputs(16'h12AF, 4'h0, 4'h0, 1'b0);
    run_cycles(400);
    set_inputs(16'h0040, 4'h0, 4'h0, 1'b1);
    run_cycles(320);
    set_inputs(16'h0040, 4'h0, 4'h0, 1'b0);
    run_cycles(320);
    set_inputs(16'h12AF, 4'b0100, 4'b0010, 1'b0);
    run_cycles(320);

    for (int i = 0; i < 24; i++) begin
      run_cycles($urandom_range(5, 150));
      randomize_inputs();
    end

    for (int i = 0; i < 6; i++) begin
      run_cycles($urandom_range(20, 200));
      pulse_reset($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) randomize_inputs();
    end
    run_cycles(200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
